// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Contents:
//   addr_t / data_t  : 32-bit byte address and data word
//   dmr_state_t      : responder FSM states
//   COUNTER_*_OFS    : offsets of the counter words from the counter base address
package data_mem_responder_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmr_state_t;

    localparam addr_t COUNTER_LO_OFS = 32'd0;
    localparam addr_t COUNTER_HI_OFS = 32'd4;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core data-memory port bundle.
// Requester (master) drives i_addr, i_wd, i_wen and i_ren.
// Responder (slave) drives o_rd, o_ready and o_err.
// o_rd and o_err are only meaningful in the cycle where o_ready=1.
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    addr_t i_addr;
    data_t i_wd;
    logic  i_wen;
    logic  i_ren;
    data_t o_rd;
    logic  o_ready;
    logic  o_err;

    modport master (
        output i_addr, i_wd, i_wen, i_ren,
        input  o_rd, o_ready, o_err
    );

    modport slave (
        input  i_addr, i_wd, i_wen, i_ren,
        output o_rd, o_ready, o_err
    );

endinterface

// File: rtl/data_mem_responder_cycle_counter64.sv
// Free-running 64-bit cycle counter with a high-word shadow register.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_snap        : copy the live high word into the shadow this edge
//   o_lo          : live low 32 bits of the count
//   o_hi          : shadowed high 32 bits
// Reading lo then hi gives a consistent 64-bit value even when the low word
// wraps between the two reads.
module cycle_counter64
    import data_mem_responder_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rstn,
    input  logic  i_snap,
    output data_t o_lo,
    output data_t o_hi
);

    logic [63:0] r_count;
    data_t       r_hi_shadow;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_count     <= '0;
            r_hi_shadow <= '0;
        end else begin
            r_count <= r_count + 64'd1;
            if (i_snap) begin
                r_hi_shadow <= r_count[63:32];
            end
        end
    end

    assign o_lo = r_count[31:0];
    assign o_hi = r_hi_shadow;

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder with ready/error handshake.
// Serves a RAM region at byte addresses [0, DEPTH_WORDS*4) and a read-only
// 64-bit cycle counter at COUNTER_ADDR (lo) / COUNTER_ADDR+4 (hi shadow).
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   bus           : slave side of data_mem_responder_if
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for i_wen|i_ren; request fields latched on accept
// WAIT  | counting down wait states, bus inputs ignored
// RESP  | o_ready=1 for one cycle with registered o_rd/o_err
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter addr_t       COUNTER_ADDR = 32'hFFFF_FF00
) (
    input  logic i_clk,
    input  logic i_rstn,
    data_mem_responder_if.slave bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    dmr_state_t    r_state;
    dmr_state_t    w_next;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_nxt;

    addr_t r_addr;
    data_t r_wd;
    logic  r_wen;
    logic  r_ren;

    data_t r_rd;
    logic  r_ready;
    logic  r_err;

    data_t r_mem [DEPTH_WORDS];

    logic  w_req;
    logic  w_commit;
    addr_t w_c_addr;
    data_t w_c_wd;
    logic  w_c_wen;
    logic  w_c_ren;
    logic  w_is_ram;
    logic  w_is_lo;
    logic  w_is_hi;
    logic  w_err;
    logic  w_ram_we;
    logic  w_snap;
    data_t w_rd_val;
    data_t w_cnt_lo;
    data_t w_cnt_hi;
    logic [AW-1:0] w_idx;

    assign w_req = bus.i_wen | bus.i_ren;

    // With zero wait states the commit edge is the accept edge, so the
    // decode has to look at the live bus instead of the latched copy.
    assign w_c_addr = (r_state == IDLE) ? bus.i_addr : r_addr;
    assign w_c_wd   = (r_state == IDLE) ? bus.i_wd   : r_wd;
    assign w_c_wen  = (r_state == IDLE) ? bus.i_wen  : r_wen;
    assign w_c_ren  = (r_state == IDLE) ? bus.i_ren  : r_ren;

    always_comb begin
        w_next     = r_state;
        w_wait_nxt = r_wait_cnt;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next = RESP;
                    end else begin
                        w_next     = WAIT;
                        w_wait_nxt = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_next = RESP;
                end else begin
                    w_wait_nxt = r_wait_cnt - 1'b1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_commit = (w_next == RESP) && (r_state != RESP);

    assign w_idx    = w_c_addr[AW+1:2];
    assign w_is_ram = w_c_addr[31:2] < 30'(DEPTH_WORDS);
    assign w_is_lo  = w_c_addr == (COUNTER_ADDR + COUNTER_LO_OFS);
    assign w_is_hi  = w_c_addr == (COUNTER_ADDR + COUNTER_HI_OFS);

    assign w_err = (|w_c_addr[1:0])
                 | (w_c_wen & w_c_ren)
                 | (~w_is_ram & ~w_is_lo & ~w_is_hi)
                 | (~w_is_ram & (w_is_lo | w_is_hi) & w_c_wen);

    // i_rstn gate keeps a zero-wait request held through reset from writing.
    assign w_ram_we = i_rstn & w_commit & ~w_err & w_is_ram & w_c_wen;
    assign w_snap   = w_commit & ~w_err & ~w_is_ram & w_is_lo;

    always_comb begin
        w_rd_val = '0;
        if (!w_err) begin
            if (w_is_ram) begin
                if (!w_c_wen) begin
                    w_rd_val = r_mem[w_idx];
                end
            end else if (w_is_lo) begin
                w_rd_val = w_cnt_lo;
            end else begin
                w_rd_val = w_cnt_hi;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_wd       <= '0;
            r_wen      <= 1'b0;
            r_ren      <= 1'b0;
            r_rd       <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
            if (r_state == IDLE && w_req) begin
                r_addr <= bus.i_addr;
                r_wd   <= bus.i_wd;
                r_wen  <= bus.i_wen;
                r_ren  <= bus.i_ren;
            end
            r_ready <= w_commit;
            r_err   <= w_commit & w_err;
            if (w_commit) begin
                r_rd <= w_rd_val;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_ram_we) begin
            r_mem[w_idx] <= w_c_wd;
        end
    end

    cycle_counter64 u_cnt (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_snap (w_snap),
        .o_lo   (w_cnt_lo),
        .o_hi   (w_cnt_hi)
    );

    assign bus.o_rd    = r_rd;
    assign bus.o_ready = r_ready;
    assign bus.o_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with one wait state, one with
// zero wait states. A scoreboard queue per instance holds expected responses
// (data, error, due cycle) computed from a behavioural memory/counter model.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] CA    = 32'hFFFF_FF00;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          due;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    int tb_cyc = 0;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    logic [31:0] drv_addr [2];
    logic [31:0] drv_wd   [2];
    logic        drv_wen  [2];
    logic        drv_ren  [2];
    logic [31:0] mon_rd   [2];
    logic        mon_ready[2];
    logic        mon_err  [2];

    data_mem_responder_if if0 ();
    data_mem_responder_if if1 ();

    assign if0.i_addr = drv_addr[0];
    assign if0.i_wd   = drv_wd[0];
    assign if0.i_wen  = drv_wen[0];
    assign if0.i_ren  = drv_ren[0];
    assign if1.i_addr = drv_addr[1];
    assign if1.i_wd   = drv_wd[1];
    assign if1.i_wen  = drv_wen[1];
    assign if1.i_ren  = drv_ren[1];
    assign mon_rd[0]    = if0.o_rd;
    assign mon_ready[0] = if0.o_ready;
    assign mon_err[0]   = if0.o_err;
    assign mon_rd[1]    = if1.o_rd;
    assign mon_ready[1] = if1.o_ready;
    assign mon_err[1]   = if1.o_err;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .COUNTER_ADDR(CA)) dut0 (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (if0)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .COUNTER_ADDR(CA)) dut1 (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (if1)
    );

    int total = 0;
    int bad   = 0;

    exp_t        sbq [2][$];
    logic [31:0] ref_mem [2][DEPTH];
    logic [31:0] m_shadow [2];
    logic [63:0] m_base [2];
    int          m_base_cyc [2];

    function automatic int wc(input int idx);
        return (idx == 0) ? 1 : 0;
    endfunction

    // Reference model: the transaction commits at the end of cycle n+wc,
    // so a counter read returns the count held during that cycle.
    task automatic model(input int idx, input logic [31:0] addr, input logic [31:0] wd,
                         input logic wen, input logic ren, input int n);
        exp_t        e;
        logic [63:0] cnt;
        e.due = n + wc(idx) + 1;
        e.err = 1'b0;
        e.rd  = 32'h0;
        cnt   = m_base[idx] + 64'(n + wc(idx) - m_base_cyc[idx]);
        if ((addr % 4) != 0 || (wen && ren)) begin
            e.err = 1'b1;
        end else if (addr < DEPTH * 4) begin
            if (wen) ref_mem[idx][addr / 4] = wd;
            else     e.rd = ref_mem[idx][addr / 4];
        end else if (addr == CA) begin
            if (wen) e.err = 1'b1;
            else begin
                e.rd          = cnt[31:0];
                m_shadow[idx] = cnt[63:32];
            end
        end else if (addr == CA + 4) begin
            if (wen) e.err = 1'b1;
            else     e.rd  = m_shadow[idx];
        end else begin
            e.err = 1'b1;
        end
        if (e.err) e.rd = 32'h0;
        sbq[idx].push_back(e);
    endtask

    task automatic mark_reset();
        for (int i = 0; i < 2; i++) begin
            m_base[i]     = 64'h0;
            m_base_cyc[i] = tb_cyc;
            m_shadow[i]   = 32'h0;
            sbq[i].delete();
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic exp_rdy;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rstn) begin
                    total++;
                    if (mon_ready[i] !== 1'b0 || mon_err[i] !== 1'b0 || mon_rd[i] !== 32'h0) begin
                        bad++;
                        $display("FAIL reset_state inst%0d ready=%b err=%b rd=%h want 0 0 00000000",
                                 i, mon_ready[i], mon_err[i], mon_rd[i]);
                    end
                end else begin
                    while (sbq[i].size() > 0 && sbq[i][0].due < tb_cyc) begin
                        e = sbq[i].pop_front();
                        total++;
                        bad++;
                        $display("FAIL missing_resp inst%0d no ready at cycle %0d, want rd=%h err=%b",
                                 i, e.due, e.rd, e.err);
                    end
                    exp_rdy = (sbq[i].size() > 0) && (sbq[i][0].due == tb_cyc);
                    total++;
                    if (mon_ready[i] !== exp_rdy) begin
                        bad++;
                        $display("FAIL ready_timing inst%0d cycle %0d ready=%b want %b",
                                 i, tb_cyc, mon_ready[i], exp_rdy);
                    end
                    if (exp_rdy) begin
                        e = sbq[i].pop_front();
                        total++;
                        if (mon_rd[i] !== e.rd || mon_err[i] !== e.err) begin
                            bad++;
                            $display("FAIL resp_data inst%0d cycle %0d rd=%h err=%b want rd=%h err=%b",
                                     i, tb_cyc, mon_rd[i], mon_err[i], e.rd, e.err);
                        end
                    end
                end
            end
        end
    endtask

    task automatic txn(input int idx, input logic [31:0] addr, input logic [31:0] wd,
                       input logic wen, input logic ren, input bit chg, input logic [31:0] alt);
        int n;
        bit got;
        @(posedge clk); #1;
        n = tb_cyc;
        drv_addr[idx] = addr;
        drv_wd[idx]   = wd;
        drv_wen[idx]  = wen;
        drv_ren[idx]  = ren;
        model(idx, addr, wd, wen, ren, n);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            if (mon_ready[idx]) got = 1'b1;
            else if (chg) drv_addr[idx] = alt;
        end
        drv_wen[idx] = 1'b0;
        drv_ren[idx] = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL timeout inst%0d addr=%h ready never seen, want ready within 20 cycles",
                     idx, addr);
        end
    endtask

    initial begin
        int          n;
        int          idx;
        int          sel;
        logic [31:0] a;
        logic        w;

        for (int i = 0; i < 2; i++) begin
            drv_addr[i] = 32'h0;
            drv_wd[i]   = 32'h0;
            drv_wen[i]  = 1'b0;
            drv_ren[i]  = 1'b0;
        end
        mark_reset();
        fork
            monitor();
        join_none

        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        mark_reset();

        // Fill the first 64 words of both RAMs with known data.
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 64; k++)
                txn(i, 32'(k * 4), $urandom, 1'b1, 1'b0, 1'b0, 32'h0);

        // One wait state: write then read back.
        txn(0, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0);
        txn(0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);

        // Zero wait states: write, read, then a request held for four responses.
        txn(1, 32'h0, 32'h1, 1'b1, 1'b0, 1'b0, 32'h0);
        txn(1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1;
        n = tb_cyc;
        drv_addr[1] = 32'h0;
        drv_ren[1]  = 1'b1;
        for (int k = 0; k < 4; k++) model(1, 32'h0, 32'h0, 1'b0, 1'b1, n + 2 * k);
        repeat (7) @(posedge clk);
        #1 drv_ren[1] = 1'b0;

        // Error cases followed by a clean read of 0x20.
        txn(0, 32'h13, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        txn(0, 32'h20, 32'h5555_AAAA, 1'b1, 1'b1, 1'b0, 32'h0);
        txn(0, 32'h1000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        txn(0, CA, 32'h1234_0000, 1'b1, 1'b0, 1'b0, 32'h0);
        txn(0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        txn(1, 32'h13, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        txn(1, CA + 4, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);

        // Counter: place the count so the lo read commits at 0x1_FFFF_FFFF.
        @(posedge clk); #1;
        force dut0.u_cnt.r_count = 64'h0000_0001_FFFF_FFFD;
        m_base[0]     = 64'h0000_0001_FFFF_FFFD;
        m_base_cyc[0] = tb_cyc;
        #1 release dut0.u_cnt.r_count;
        txn(0, CA, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        txn(0, CA + 4, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);

        // Reset during the WAIT cycle of a write to 0x40.
        @(posedge clk); #1;
        drv_addr[0] = 32'h40;
        drv_wd[0]   = ~ref_mem[0][16];
        drv_wen[0]  = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drv_wen[0] = 1'b0;
        rstn       = 1'b1;
        mark_reset();
        repeat (4) @(posedge clk);
        txn(0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        txn(0, CA, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        txn(1, CA, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);

        // Address change during WAIT is ignored.
        txn(0, 32'h14, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0);
        txn(0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'h14);

        // Randomised mix on both instances.
        for (int t = 0; t < 160; t++) begin
            idx = t % 2;
            sel = $urandom_range(0, 9);
            w   = 1'($urandom_range(0, 1));
            case (sel)
                6:       a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                7:       a = ($urandom_range(0, 1) == 1) ? CA + 4 : CA;
                8:       a = 32'h1000 + 32'($urandom_range(0, 4000) * 4);
                default: a = 32'($urandom_range(0, 63) * 4);
            endcase
            if (sel == 9) txn(idx, a, $urandom, 1'b1, 1'b1, 1'b0, 32'h0);
            else          txn(idx, a, $urandom, w, ~w, 1'b0, 32'h0);
        end

        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (sbq[i].size() != 0) begin
                bad++;
                $display("FAIL drain inst%0d pending=%0d want 0", i, sbq[i].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
